press_classifier: RTL



---
 rtl/press_classifier_pkg.sv | 18 +
 rtl/press_classifier_if.sv | 27 ++
 rtl/edge_detect.sv | 23 ++
 rtl/press_classifier.sv | 107 ++++++++++
 4 files changed

// File: rtl/press_classifier_pkg.sv
// Shared state encoding and default 25 MHz timing constants
// for the press classifier and other board timing blocks.
package press_classifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT_GAP  = 3'd2,
        ST_PRESS2    = 3'd3,
        ST_LONG_HELD = 3'd4
    } state_t;

    localparam int CLK_HZ          = 25_000_000;
    localparam int LONG_CYCLES_DEF = 25_000_000;
    localparam int GAP_CYCLES_DEF  = 6_250_000;
    localparam int CNT_W_DEF       = 25;

endpackage

// File: rtl/press_classifier_if.sv
// Switch-in / gesture-out bundle between the debounce stage
// and the LED / mode-select consumers.
interface press_classifier_if;

    logic i_Switch;
    logic o_Short_Pulse;
    logic o_Double_Pulse;
    logic o_Long_Pulse;
    logic o_Held;

    modport master (
        output i_Switch,
        input  o_Short_Pulse,
        input  o_Double_Pulse,
        input  o_Long_Pulse,
        input  o_Held
    );

    modport slave (
        input  i_Switch,
        output o_Short_Pulse,
        output o_Double_Pulse,
        output o_Long_Pulse,
        output o_Held
    );

endinterface

// File: rtl/edge_detect.sv
// Registered previous value with programmable reset level;
// rise/fall strobes are valid in the cycle the new level is seen.
module edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sig,
    output logic o_Rise,
    output logic o_Fall
);

    logic r_Prev;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) r_Prev <= RST_VAL;
        else          r_Prev <= i_Sig;
    end

    assign o_Rise = i_Sig & ~r_Prev;
    assign o_Fall = ~i_Sig & r_Prev;

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced switch gestures into short, double
// and long presses; one registered pulse per gesture.
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input logic i_Clk,
    input logic i_Rst_L,
    press_classifier_if.slave bus
);

    localparam logic [CNT_W-1:0] LONG_MAX =
        CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_MAX =
        CNT_W'(GAP_CYCLES - 1);

    state_t           r_State;
    logic [CNT_W-1:0] r_Cnt;
    logic             r_Short;
    logic             r_Double;
    logic             r_Long;
    logic             r_Held;
    logic             w_Rise;
    logic             w_Fall;

    // Reset level 1 so a switch held through reset is not a press.
    edge_detect #(.RST_VAL(1'b1)) u_edge (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Sig  (bus.i_Switch),
        .o_Rise (w_Rise),
        .o_Fall (w_Fall)
    );

    // Inside PRESS*/LONG_HELD the switch was high last cycle, and
    // inside WAIT_GAP it was low, so the strobes equal the raw level.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State  <= ST_IDLE;
            r_Cnt    <= '0;
            r_Short  <= 1'b0;
            r_Double <= 1'b0;
            r_Long   <= 1'b0;
            r_Held   <= 1'b0;
        end else begin
            r_Short  <= 1'b0;
            r_Double <= 1'b0;
            r_Long   <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    r_Held <= 1'b0;
                    if (w_Rise) begin
                        r_State <= ST_PRESS1;
                        r_Cnt   <= '0;
                    end
                end
                ST_PRESS1: begin
                    if (w_Fall) begin
                        r_State <= ST_WAIT_GAP;
                        r_Cnt   <= '0;
                    end else if (r_Cnt == LONG_MAX) begin
                        r_State <= ST_LONG_HELD;
                        r_Long  <= 1'b1;
                        r_Held  <= 1'b1;
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
                ST_WAIT_GAP: begin
                    if (w_Rise) begin
                        r_State <= ST_PRESS2;
                    end else if (r_Cnt == GAP_MAX) begin
                        r_State <= ST_IDLE;
                        r_Short <= 1'b1;
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
                ST_PRESS2: begin
                    if (w_Fall) begin
                        r_State  <= ST_IDLE;
                        r_Double <= 1'b1;
                    end
                end
                ST_LONG_HELD: begin
                    if (w_Fall) begin
                        r_State <= ST_IDLE;
                        r_Held  <= 1'b0;
                    end
                end
                default: begin
                    r_State <= ST_IDLE;
                    r_Held  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Short_Pulse  = r_Short;
    assign bus.o_Double_Pulse = r_Double;
    assign bus.o_Long_Pulse   = r_Long;
    assign bus.o_Held         = r_Held;

endmodule
